regfile_wb_arb: RTL and testbench

Write-back arbiter and scoreboard for the register file's single write port. Up to NREQ producers (ALU, load unit, CSR unit) present write-back requests with valid/ready handshakes. The block grants one request per cycle and drives a registered write to the register file. It also keeps a per-register busy scoreboard, which decode uses for RAW-hazard stalls.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 66 ++++++
 rtl/regfile_wb_arb.sv | 119 +++++++++++
 tb/tb_regfile_wb_arb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file sizing and types.
//   RF_N  - number of architectural registers
//   RF_W  - register data width
//   RF_AW - register address width
// Imported by regfile_wb_arb and regfile_ff.
package regfile_pkg;

    localparam int RF_N  = 32;
    localparam int RF_W  = 32;
    localparam int RF_AW = $clog2(RF_N);

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_W-1:0]  rf_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant selection for the write-back port.
//   req     in  NREQ  request vector
//   ptr     in  PW    index of the highest-priority requester (round-robin only)
//   accept  in  1     the current grant is being taken this cycle
//   grant   out NREQ  one-hot grant, zero when no request
//   ptr_nxt out PW    pointer for the next cycle
// Macro REGFILE_WB_RR_EN selects round-robin; otherwise fixed priority with
// index 0 highest, and ptr/accept are ignored.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            accept,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   ptr_nxt
);

`ifdef REGFILE_WB_RR_EN
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    // Scan requesters starting at ptr, wrapping modulo NREQ; first hit wins.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        sum     = '0;
        idx     = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                if (accept) begin
                    ptr_nxt = (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
                end
            end
        end
    end
`else
    logic found;
    logic unused_rr_in;

    assign unused_rr_in = ^{ptr, accept};
    assign ptr_nxt      = '0;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: write-back arbiter and busy scoreboard for the register
// file's single write port.
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     per-requester handshake (ready is one-hot or zero)
//   req_addr/req_data   flattened per-requester destination and data
//   res_valid/res_addr  decode reserves a destination register
//   rf_wen/waddr/wdata  registered register-file write
//   busy                per-register outstanding-producer scoreboard
//   err_dbl             sticky double-reservation flag
// Macro REGFILE_WB_RR_EN: round-robin arbitration (else fixed priority).
module regfile_wb_arb
    import regfile_pkg::*;
#(
    parameter int N    = RF_N,
    parameter int W    = RF_W,
    parameter int NREQ = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*$clog2(N)-1:0]   req_addr,
    input  logic [NREQ*W-1:0]           req_data,
    input  logic                        res_valid,
    input  logic [$clog2(N)-1:0]        res_addr,
    output logic                        rf_wen,
    output logic [$clog2(N)-1:0]        rf_waddr,
    output logic [W-1:0]                rf_wdata,
    output logic [N-1:0]                busy,
    output logic                        err_dbl
);

    localparam int AW = $clog2(N);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] arb_grant;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_nxt;
    logic            vld_p0;
    logic [AW-1:0]   addr_p0;
    logic [W-1:0]    data_p0;
    logic            res_hit;
    logic            clr_same;
    logic [N-1:0]    busy_nxt;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .accept  (vld_p0),
        .grant   (arb_grant),
        .ptr_nxt (ptr_nxt)
    );

    // Stage p0: grant and select the accepted request.
    assign req_ready = rst ? '0 : arb_grant;
    assign vld_p0    = |req_ready;

    always_comb begin
        addr_p0 = '0;
        data_p0 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                addr_p0 = req_addr[i*AW +: AW];
                data_p0 = req_data[i*W +: W];
            end
        end
    end

    // Reserve is applied after clear so a same-cycle reserve keeps the bit set.
    assign res_hit  = res_valid && (res_addr != '0);
    assign clr_same = vld_p0 && (addr_p0 == res_addr);

    always_comb begin
        busy_nxt = busy;
        if (vld_p0) begin
            busy_nxt[addr_p0] = 1'b0;
        end
        if (res_hit) begin
            busy_nxt[res_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

`ifdef REGFILE_WB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_nxt;
        end
    end
`else
    logic unused_ptr;
    assign ptr_q      = '0;
    assign unused_ptr = ^ptr_nxt;
`endif

    // Stage p1: registered write port, scoreboard and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            busy     <= '0;
            err_dbl  <= 1'b0;
        end else begin
            rf_wen <= vld_p0 && (addr_p0 != '0);
            if (vld_p0) begin
                rf_waddr <= addr_p0;
                rf_wdata <= data_p0;
            end
            busy <= busy_nxt;
            if (res_hit && busy[res_addr] && !clr_same) begin
                err_dbl <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// tb_regfile_wb_arb: directed and randomized bench for regfile_wb_arb with a
// per-register array model of the scoreboard and write port.
module tb_regfile_wb_arb;

    localparam int N    = 32;
    localparam int W    = 32;
    localparam int NREQ = 3;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*W-1:0]    req_data;
    logic                 res_valid;
    logic [AW-1:0]        res_addr;
    logic                 rf_wen;
    logic [AW-1:0]        rf_waddr;
    logic [W-1:0]         rf_wdata;
    logic [N-1:0]         busy;
    logic                 err_dbl;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_busy [N];
    bit          m_err;
    int          m_ptr;
    bit          m_wen;
    bit          m_wknown;
    int          m_waddr;
    logic [W-1:0] m_wdata;
    int          obs_log [$];

    always #5 clk = ~clk;

    regfile_wb_arb #(.N(N), .W(W), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .res_valid (res_valid),
        .res_addr  (res_addr),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy),
        .err_dbl   (err_dbl)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
`ifdef REGFILE_WB_RR_EN
            int i = (m_ptr + k) % NREQ;
`else
            int i = k;
`endif
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] pack_busy();
        logic [N-1:0] b = '0;
        for (int r = 0; r < N; r++) b[r] = m_busy[r];
        return b;
    endfunction

    // One clock: drive inputs, check grant, advance model, check registered outputs.
    task automatic step(input logic r, input logic [NREQ-1:0] v,
                        input int a0, input int a1, input int a2,
                        input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2,
                        input logic rv, input int ra);
        int           addrs [NREQ];
        logic [W-1:0] datas [NREQ];
        int           g;
        int           og;
        bit           prior;
        addrs = '{a0, a1, a2};
        datas = '{d0, d1, d2};
        rst       = r;
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = addrs[i][AW-1:0];
            req_data[i*W +: W]   = datas[i];
        end
        res_valid = rv;
        res_addr  = ra[AW-1:0];
        #1;
        g = r ? -1 : pick(v);
        chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        og = -1;
        for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) og = i;
        obs_log.push_back(og);

        if (r) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            m_err = 1'b0; m_ptr = 0; m_wen = 1'b0; m_wknown = 1'b1;
            m_waddr = 0; m_wdata = '0;
        end else begin
            prior = (ra >= 0 && ra < N) ? m_busy[ra] : 1'b0;
            if (g >= 0) begin
                m_wen = (addrs[g] != 0);
                if (addrs[g] != 0) begin
                    m_wknown = 1'b1; m_waddr = addrs[g]; m_wdata = datas[g];
                end else begin
                    m_wknown = 1'b0;
                end
                m_busy[addrs[g]] = 1'b0;
                m_ptr = (g + 1) % NREQ;
            end else begin
                m_wen = 1'b0;
            end
            if (rv && ra != 0) begin
                if (prior && !(g >= 0 && addrs[g] == ra)) m_err = 1'b1;
                m_busy[ra] = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        chk("rf_wen", 64'(rf_wen), 64'(m_wen));
        if (m_wknown) begin
            chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
            chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        end
        chk("busy", 64'(busy), 64'(pack_busy()));
        chk("err_dbl", 64'(err_dbl), 64'(m_err));
    endtask

    task automatic idle();
        step(1'b0, 3'b000, 0, 0, 0, '0, '0, '0, 1'b0, 0);
    endtask

    initial begin
        int v_s, a0, a1, a2, ra;
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        res_valid = 1'b0; res_addr = '0;
        m_wknown = 1'b0; m_err = 1'b0; m_ptr = 0; m_wen = 1'b0;

        // Reset with all requesters valid, then idle
        step(1'b1, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 1'b1, 4);
        idle();
        chk("idle_busy_zero", 64'(busy), 64'd0);

        // Reserve x5, requester 1 writes x5 two cycles later
        step(1'b0, 3'b000, 0, 0, 0, '0, '0, '0, 1'b1, 5);
        chk("busy5_set", 64'(busy[5]), 64'd1);
        idle();
        step(1'b0, 3'b010, 0, 5, 0, '0, 32'hDEADBEEF, '0, 1'b0, 0);
        chk("busy5_clr", 64'(busy[5]), 64'd0);
        chk("wr5_wen", 64'(rf_wen), 64'd1);
        chk("wr5_addr", 64'(rf_waddr), 64'd5);
        chk("wr5_data", 64'(rf_wdata), 64'hDEADBEEF);
        idle();

        // Six cycles of all requesters valid starting from pointer 0
        step(1'b1, 3'b000, 0, 0, 0, '0, '0, '0, 1'b0, 0);
        obs_log.delete();
        for (int c = 0; c < 6; c++)
            step(1'b0, 3'b111, 10, 11, 12, 32'hA0 + c, 32'hB0 + c, 32'hC0 + c, 1'b0, 0);
        for (int c = 0; c < 6; c++) begin
`ifdef REGFILE_WB_RR_EN
            chk("grant_seq", 64'(obs_log[c]), 64'(c % 3));
`else
            chk("grant_seq", 64'(obs_log[c]), 64'd0);
`endif
        end

        // Write to x0: accepted but no register-file write
        step(1'b0, 3'b001, 0, 0, 0, 32'h1234, '0, '0, 1'b0, 0);
        chk("x0_wen", 64'(rf_wen), 64'd0);
        idle();

        // Same-cycle reserve and write of x7, then double reserve
        step(1'b0, 3'b000, 0, 0, 0, '0, '0, '0, 1'b1, 7);
        step(1'b0, 3'b001, 7, 0, 0, 32'h77, '0, '0, 1'b1, 7);
        chk("busy7_kept", 64'(busy[7]), 64'd1);
        chk("err_not_yet", 64'(err_dbl), 64'd0);
        step(1'b0, 3'b000, 0, 0, 0, '0, '0, '0, 1'b1, 7);
        chk("err_set", 64'(err_dbl), 64'd1);
        idle();
        idle();
        chk("err_sticky", 64'(err_dbl), 64'd1);

        // Reset while requester 2 valid and x3 busy
        step(1'b0, 3'b000, 0, 0, 0, '0, '0, '0, 1'b1, 3);
        step(1'b1, 3'b100, 0, 0, 3, '0, '0, 32'h33, 1'b0, 0);
        chk("rst_wen", 64'(rf_wen), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_dbl), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            v_s = int'($urandom_range(0, 7));
            a0  = int'($urandom_range(0, N - 1));
            a1  = int'($urandom_range(0, N - 1));
            a2  = int'($urandom_range(0, N - 1));
            ra  = int'($urandom_range(0, N - 1));
            step(($urandom_range(0, 49) == 0), v_s[NREQ-1:0], a0, a1, a2,
                 $urandom, $urandom, $urandom, ($urandom_range(0, 2) != 0), ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
